// File: rtl/round_sequencer_if.sv
// round_sequencer_if
//   Bundles the game-flow signals between the ball/paddle datapath and the
//   round sequencer. Clock and reset are not part of the bundle.
//
//   master : environment side (drives strobes/levels, observes controls)
//   slave  : round_sequencer side
//
//   tick        1            one-cycle ball refresh strobe
//   start       1            start button level (edge detected by sequencer)
//   pause       1            pause level
//   ballX       X_WIDTH      current ball X position
//   paddleHit   1            paddle collision flag
//   ballReset   1            ball held at centre
//   ballEnable  1            ball mover may advance
//   serveDir    1            0 = serve left, 1 = serve right
//   leftScore   SCORE_WIDTH  left player score
//   rightScore  SCORE_WIDTH  right player score
//   winner      2            00 none, 01 left, 10 right
//   phase       3            sequencer state
//   rallyCount  8            (ROUND_SEQUENCER_RALLY_EN only) hits this rally
//   bestRally   8            (ROUND_SEQUENCER_RALLY_EN only) longest rally
interface round_sequencer_if #(
  parameter int unsigned X_WIDTH     = 8,
  parameter int unsigned SCORE_WIDTH = 4
);

  logic                   tick;
  logic                   start;
  logic                   pause;
  logic [X_WIDTH-1:0]     ballX;
  logic                   paddleHit;
  logic                   ballReset;
  logic                   ballEnable;
  logic                   serveDir;
  logic [SCORE_WIDTH-1:0] leftScore;
  logic [SCORE_WIDTH-1:0] rightScore;
  logic [1:0]             winner;
  logic [2:0]             phase;
`ifdef ROUND_SEQUENCER_RALLY_EN
  logic [7:0]             rallyCount;
  logic [7:0]             bestRally;
`endif

  modport master (
    output tick, start, pause, ballX, paddleHit,
`ifdef ROUND_SEQUENCER_RALLY_EN
    input  rallyCount, bestRally,
`endif
    input  ballReset, ballEnable, serveDir, leftScore, rightScore, winner, phase
  );

  modport slave (
    input  tick, start, pause, ballX, paddleHit,
`ifdef ROUND_SEQUENCER_RALLY_EN
    output rallyCount, bestRally,
`endif
    output ballReset, ballEnable, serveDir, leftScore, rightScore, winner, phase
  );

endinterface

// File: rtl/round_sequencer.sv
// round_sequencer
//   Game-flow controller for the ball/paddle game. Walks each match through
//   IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER) -> IDLE, gates the ball
//   mover (ballReset / ballEnable), owns both score registers and declares
//   the winner. All outputs are registered.
//
//   Ports:
//     clock    system clock
//     reset_n  synchronous active-low reset
//     bus      round_sequencer_if.slave (tick/start/pause/ballX/paddleHit in;
//              ballReset/ballEnable/serveDir/scores/winner/phase out)
//
//   Optional feature macro: ROUND_SEQUENCER_RALLY_EN
//     Adds rallyCount (paddle hits in the current rally, saturating) and
//     bestRally (longest rally since reset) to the interface.
module round_sequencer #(
  parameter int unsigned X_WIDTH      = 8,
  parameter int unsigned SCORE_WIDTH  = 4,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned LEFT_GOAL_X  = 5,
  parameter int unsigned RIGHT_GOAL_X = 230,
  parameter int unsigned SERVE_TICKS  = 60,
  parameter int unsigned OVER_TICKS   = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  round_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_e;

  // One shared tick counter serves both the SERVE hold and the OVER hold.
  localparam int unsigned MAX_TICKS = (SERVE_TICKS > OVER_TICKS) ? SERVE_TICKS : OVER_TICKS;
  localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [CNT_W-1:0]       SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0]       OVER_LAST  = CNT_W'(OVER_TICKS - 1);
  localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [X_WIDTH-1:0]     LEFT_X     = X_WIDTH'(LEFT_GOAL_X);
  localparam logic [X_WIDTH-1:0]     RIGHT_X    = X_WIDTH'(RIGHT_GOAL_X);

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   start_q;
  logic [SCORE_WIDTH-1:0] lscore_q, lscore_d;
  logic [SCORE_WIDTH-1:0] rscore_q, rscore_d;
  logic [1:0]             winner_q, winner_d;
  logic                   ball_reset_q, ball_reset_d;
  logic                   ball_enable_q, ball_enable_d;
  logic                   serve_dir_q, serve_dir_d;
  // Remembers which side scored in PLAY so POINT knows which register to bump.
  logic                   scorer_left_q, scorer_left_d;

  logic                   start_edge;
  logic                   tick_run;
  logic [SCORE_WIDTH-1:0] lscore_inc;
  logic [SCORE_WIDTH-1:0] rscore_inc;

  assign start_edge = bus.start & ~start_q;
  assign tick_run   = bus.tick & ~bus.pause;
  assign lscore_inc = lscore_q + SCORE_WIDTH'(1);
  assign rscore_inc = rscore_q + SCORE_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lscore_d      = lscore_q;
    rscore_d      = rscore_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;
    scorer_left_d = scorer_left_q;
    ball_reset_d  = 1'b1;
    ball_enable_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d  = SERVE;
          cnt_d    = '0;
          lscore_d = '0;
          rscore_d = '0;
          winner_d = WIN_NONE;
        end
      end

      SERVE: begin
        if (tick_run) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      PLAY: begin
        // Left goal is tested first so it wins if both thresholds overlap.
        if (tick_run) begin
          if (bus.ballX <= LEFT_X) begin
            state_d       = POINT;
            scorer_left_d = 1'b0;
          end else if (bus.ballX >= RIGHT_X) begin
            state_d       = POINT;
            scorer_left_d = 1'b1;
          end
        end
      end

      POINT: begin
        cnt_d = '0;
        if (scorer_left_q) begin
          lscore_d    = lscore_inc;
          serve_dir_d = 1'b1;
          if (lscore_inc == WIN_VAL) begin
            state_d  = OVER;
            winner_d = WIN_LEFT;
          end else begin
            state_d = SERVE;
          end
        end else begin
          rscore_d    = rscore_inc;
          serve_dir_d = 1'b0;
          if (rscore_inc == WIN_VAL) begin
            state_d  = OVER;
            winner_d = WIN_RIGHT;
          end else begin
            state_d = SERVE;
          end
        end
      end

      OVER: begin
        // A start edge exits regardless of the tick in the same cycle.
        if (start_edge || (tick_run && (cnt_q == OVER_LAST))) begin
          state_d  = IDLE;
          cnt_d    = '0;
          lscore_d = '0;
          rscore_d = '0;
          winner_d = WIN_NONE;
        end else if (tick_run) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they change together
    // with phase, one clock after the deciding inputs are sampled.
    if (state_d == PLAY) begin
      ball_reset_d  = 1'b0;
      ball_enable_d = ~bus.pause;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      lscore_q      <= '0;
      rscore_q      <= '0;
      winner_q      <= WIN_NONE;
      ball_reset_q  <= 1'b1;
      ball_enable_q <= 1'b0;
      serve_dir_q   <= 1'b0;
      scorer_left_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_q       <= bus.start;
      lscore_q      <= lscore_d;
      rscore_q      <= rscore_d;
      winner_q      <= winner_d;
      ball_reset_q  <= ball_reset_d;
      ball_enable_q <= ball_enable_d;
      serve_dir_q   <= serve_dir_d;
      scorer_left_q <= scorer_left_d;
    end
  end

  assign bus.ballReset  = ball_reset_q;
  assign bus.ballEnable = ball_enable_q;
  assign bus.serveDir   = serve_dir_q;
  assign bus.leftScore  = lscore_q;
  assign bus.rightScore = rscore_q;
  assign bus.winner     = winner_q;
  assign bus.phase      = state_q;

`ifdef ROUND_SEQUENCER_RALLY_EN
  // ---------------------------------------------------------------------------
  // Rally statistics
  // ---------------------------------------------------------------------------
  logic [7:0] rally_q, rally_d;
  logic [7:0] best_q, best_d;

  always_comb begin
    rally_d = rally_q;
    best_d  = best_q;
    if ((state_q == PLAY) && tick_run && bus.paddleHit && (rally_q != 8'hFF)) begin
      rally_d = rally_q + 8'd1;
    end
    if ((state_q == POINT) && (rally_q > best_q)) begin
      best_d = rally_q;
    end
    if ((state_d == SERVE) && (state_q != SERVE)) begin
      rally_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rally_q <= '0;
      best_q  <= '0;
    end else begin
      rally_q <= rally_d;
      best_q  <= best_d;
    end
  end

  assign bus.rallyCount = rally_q;
  assign bus.bestRally  = best_q;
`else
  // paddleHit only feeds the rally statistics.
  logic unused_paddle_hit;
  assign unused_paddle_hit = bus.paddleHit;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer
//   Self-checking bench for round_sequencer: a vector table walks reset,
//   idle, serve timing, goal thresholds and pause; hand-written sequences
//   cover full matches, game-over exits and reset mid-match.
module tb_round_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  round_sequencer_if #(.X_WIDTH(8), .SCORE_WIDTH(4)) bus ();

  round_sequencer #(
    .X_WIDTH     (8),
    .SCORE_WIDTH (4),
    .WIN_SCORE   (7),
    .LEFT_GOAL_X (5),
    .RIGHT_GOAL_X(230),
    .SERVE_TICKS (60),
    .OVER_TICKS  (255)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [15:0] reps;
    logic        rst_n;
    logic        tick;
    logic        start;
    logic        pause;
    logic [7:0]  x;
    logic        hit;
    logic [2:0]  ph;
    logic        brst;
    logic        ben;
    logic        sdir;
    logic [3:0]  ls;
    logic [3:0]  rs;
    logic [1:0]  win;
  } vec_t;

  typedef struct packed {
    logic [2:0] ph;
    logic       brst;
    logic       ben;
    logic       sdir;
    logic [3:0] ls;
    logic [3:0] rs;
    logic [1:0] win;
  } exp_t;

  exp_t  sb[$];
  string sbn[$];

  int n_checks = 0;
  int n_errors = 0;

  localparam int NV = 15;
  vec_t  tbl[NV];
  string tnm[NV];

  function automatic vec_t mk(input int reps, input logic rn, input logic tk,
                              input logic st, input logic pz, input logic [7:0] x,
                              input logic hit, input logic [2:0] ph, input logic br,
                              input logic be, input logic sd, input logic [3:0] ls,
                              input logic [3:0] rs, input logic [1:0] w);
    vec_t v;
    v.reps = 16'(reps); v.rst_n = rn; v.tick = tk; v.start = st; v.pause = pz;
    v.x = x; v.hit = hit; v.ph = ph; v.brst = br; v.ben = be; v.sdir = sd;
    v.ls = ls; v.rs = rs; v.win = w;
    return v;
  endfunction

  task automatic chk(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s got=%0h expected=%0h", nm, f, act, exp);
    end
  endtask

  // Hold one input vector for v.reps clocks; the outcome after the last clock
  // is queued as it is driven and compared once the DUT has registered it.
  task automatic step(input string nm, input vec_t v);
    exp_t  e;
    string n;
    for (int i = 0; i < int'(v.reps); i++) begin
      rst_n         = v.rst_n;
      bus.tick      = v.tick;
      bus.start     = v.start;
      bus.pause     = v.pause;
      bus.ballX     = v.x;
      bus.paddleHit = v.hit;
      if (i == int'(v.reps) - 1) begin
        e.ph = v.ph; e.brst = v.brst; e.ben = v.ben; e.sdir = v.sdir;
        e.ls = v.ls; e.rs = v.rs; e.win = v.win;
        sb.push_back(e);
        sbn.push_back(nm);
      end
      @(posedge clk);
      #1;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n = sbn.pop_front();
      chk(n, "phase",      32'(bus.phase),      32'(e.ph));
      chk(n, "ballReset",  32'(bus.ballReset),  32'(e.brst));
      chk(n, "ballEnable", 32'(bus.ballEnable), 32'(e.ben));
      chk(n, "serveDir",   32'(bus.serveDir),   32'(e.sdir));
      chk(n, "leftScore",  32'(bus.leftScore),  32'(e.ls));
      chk(n, "rightScore", 32'(bus.rightScore), 32'(e.rs));
      chk(n, "winner",     32'(bus.winner),     32'(e.win));
    end
  endtask

  // From PLAY: left scores until 7, re-serving between points.
  task automatic left_to_over(input logic sdir_in, input logic [3:0] rs);
    logic sd;
    sd = sdir_in;
    for (int k = 1; k <= 7; k++) begin
      step("goalL", mk(1, 1, 1, 0, 0, 8'd230, 0, 3'd3, 1, 0, sd, 4'(k - 1), rs, 2'b00));
      if (k < 7) begin
        step("reserveL", mk(1, 1, 0, 0, 0, 8'd100, 0, 3'd1, 1, 0, 1, 4'(k), rs, 2'b00));
        step("serveL",   mk(60, 1, 1, 0, 0, 8'd100, 0, 3'd2, 0, 1, 1, 4'(k), rs, 2'b00));
      end else begin
        step("overL", mk(1, 1, 0, 0, 0, 8'd100, 0, 3'd4, 1, 0, 1, 4'd7, rs, 2'b01));
      end
      sd = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.ballX = 8'd100; bus.paddleHit = 1'b0;

    //              reps rn tk st pz x       h  ph    br be sd ls    rs    win
    tnm[0]  = "reset";      tbl[0]  = mk(2,   0, 0, 0, 0, 8'd100, 0, 3'd0, 1, 0, 0, 4'd0, 4'd0, 2'b00);
    tnm[1]  = "idle100";    tbl[1]  = mk(100, 1, 1, 0, 0, 8'd100, 0, 3'd0, 1, 0, 0, 4'd0, 4'd0, 2'b00);
    tnm[2]  = "start";      tbl[2]  = mk(1,   1, 0, 1, 0, 8'd100, 0, 3'd1, 1, 0, 0, 4'd0, 4'd0, 2'b00);
    tnm[3]  = "serve59";    tbl[3]  = mk(59,  1, 1, 1, 0, 8'd100, 0, 3'd1, 1, 0, 0, 4'd0, 4'd0, 2'b00);
    tnm[4]  = "serve60";    tbl[4]  = mk(1,   1, 1, 1, 0, 8'd100, 0, 3'd2, 0, 1, 0, 4'd0, 4'd0, 2'b00);
    tnm[5]  = "x6";         tbl[5]  = mk(1,   1, 1, 0, 0, 8'd6,   0, 3'd2, 0, 1, 0, 4'd0, 4'd0, 2'b00);
    tnm[6]  = "x229";       tbl[6]  = mk(1,   1, 1, 0, 0, 8'd229, 0, 3'd2, 0, 1, 0, 4'd0, 4'd0, 2'b00);
    tnm[7]  = "x5";         tbl[7]  = mk(1,   1, 1, 0, 0, 8'd5,   0, 3'd3, 1, 0, 0, 4'd0, 4'd0, 2'b00);
    tnm[8]  = "pointExit";  tbl[8]  = mk(1,   1, 0, 0, 0, 8'd100, 0, 3'd1, 1, 0, 0, 4'd0, 4'd1, 2'b00);
    tnm[9]  = "serve30";    tbl[9]  = mk(30,  1, 1, 0, 0, 8'd100, 0, 3'd1, 1, 0, 0, 4'd0, 4'd1, 2'b00);
    tnm[10] = "pause50";    tbl[10] = mk(50,  1, 1, 0, 1, 8'd100, 0, 3'd1, 1, 0, 0, 4'd0, 4'd1, 2'b00);
    tnm[11] = "serve29";    tbl[11] = mk(29,  1, 1, 0, 0, 8'd100, 0, 3'd1, 1, 0, 0, 4'd0, 4'd1, 2'b00);
    tnm[12] = "serveLast";  tbl[12] = mk(1,   1, 1, 0, 0, 8'd100, 0, 3'd2, 0, 1, 0, 4'd0, 4'd1, 2'b00);
    tnm[13] = "pausedX5";   tbl[13] = mk(3,   1, 1, 0, 1, 8'd5,   0, 3'd2, 0, 0, 0, 4'd0, 4'd1, 2'b00);
    tnm[14] = "unpause";    tbl[14] = mk(1,   1, 0, 0, 0, 8'd100, 0, 3'd2, 0, 1, 0, 4'd0, 4'd1, 2'b00);

    for (int i = 0; i < NV; i++) step(tnm[i], tbl[i]);

    // Match 1: left wins 7-1, then start edge returns to idle.
    left_to_over(1'b0, 4'd1);
    step("overStart",  mk(1, 1, 0, 1, 0, 8'd100, 0, 3'd0, 1, 0, 1, 4'd0, 4'd0, 2'b00));
    step("idleHeld",   mk(5, 1, 1, 1, 0, 8'd100, 0, 3'd0, 1, 0, 1, 4'd0, 4'd0, 2'b00));
    step("startLow",   mk(1, 1, 0, 0, 0, 8'd100, 0, 3'd0, 1, 0, 1, 4'd0, 4'd0, 2'b00));

    // Match 2: left wins 7-0, game-over times out on its own.
    step("start2",     mk(1,  1, 0, 1, 0, 8'd100, 0, 3'd1, 1, 0, 1, 4'd0, 4'd0, 2'b00));
    step("serve2",     mk(60, 1, 1, 0, 0, 8'd100, 0, 3'd2, 0, 1, 1, 4'd0, 4'd0, 2'b00));
    left_to_over(1'b1, 4'd0);
    step("overHold",   mk(254, 1, 1, 0, 0, 8'd100, 0, 3'd4, 1, 0, 1, 4'd7, 4'd0, 2'b01));
    step("overAuto",   mk(1,   1, 1, 0, 0, 8'd100, 0, 3'd0, 1, 0, 1, 4'd0, 4'd0, 2'b00));

    // Match 3: reset while in PLAY with leftScore=3.
    step("start3",     mk(1,  1, 0, 1, 0, 8'd100, 0, 3'd1, 1, 0, 1, 4'd0, 4'd0, 2'b00));
    step("serve3",     mk(60, 1, 1, 1, 0, 8'd100, 0, 3'd2, 0, 1, 1, 4'd0, 4'd0, 2'b00));
    for (int k = 1; k <= 3; k++) begin
      step("m3goal",  mk(1,  1, 1, 0, 0, 8'd230, 0, 3'd3, 1, 0, 1, 4'(k - 1), 4'd0, 2'b00));
      step("m3serve", mk(1,  1, 0, 0, 0, 8'd100, 0, 3'd1, 1, 0, 1, 4'(k),     4'd0, 2'b00));
      step("m3play",  mk(60, 1, 1, 0, 0, 8'd100, 0, 3'd2, 0, 1, 1, 4'(k),     4'd0, 2'b00));
    end
    step("midReset",   mk(1, 0, 1, 0, 0, 8'd100, 0, 3'd0, 1, 0, 0, 4'd0, 4'd0, 2'b00));
`ifdef ROUND_SEQUENCER_RALLY_EN
    chk("midReset", "rallyCount", 32'(bus.rallyCount), 32'd0);
    chk("midReset", "bestRally",  32'(bus.bestRally),  32'd0);
`endif

    // Match 4: four paddle hits, then right scores.
    step("start4",     mk(1,  1, 0, 1, 0, 8'd100, 0, 3'd1, 1, 0, 0, 4'd0, 4'd0, 2'b00));
    step("serve4",     mk(60, 1, 1, 0, 0, 8'd100, 0, 3'd2, 0, 1, 0, 4'd0, 4'd0, 2'b00));
    step("hits",       mk(4,  1, 1, 0, 0, 8'd100, 1, 3'd2, 0, 1, 0, 4'd0, 4'd0, 2'b00));
`ifdef ROUND_SEQUENCER_RALLY_EN
    chk("hits", "rallyCount", 32'(bus.rallyCount), 32'd4);
    chk("hits", "bestRally",  32'(bus.bestRally),  32'd0);
`endif
    step("goalR",      mk(1, 1, 1, 0, 0, 8'd5,   0, 3'd3, 1, 0, 0, 4'd0, 4'd0, 2'b00));
    step("reserveR",   mk(1, 1, 0, 0, 0, 8'd100, 0, 3'd1, 1, 0, 0, 4'd0, 4'd1, 2'b00));
`ifdef ROUND_SEQUENCER_RALLY_EN
    chk("reserveR", "rallyCount", 32'(bus.rallyCount), 32'd0);
    chk("reserveR", "bestRally",  32'(bus.bestRally),  32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
